// File: rtl/r4_out_serializer_pkg.sv
// Shared FFT definitions for the radix-4 output serializer.
// Latency: none (types, constants and a helper only).
// Backpressure: not applicable.
package r4_out_serializer_pkg;

  localparam int WL_DEFAULT = 16;
  localparam int LANES      = 4;
  localparam int IDX_W      = $clog2(LANES);

  // Complex sample at the default word length: real/imag pair.
  typedef struct packed {
    logic [WL_DEFAULT-1:0] re;
    logic [WL_DEFAULT-1:0] im;
  } cplx_t;

  // True when the lane index points at the last lane of a group.
  function automatic logic is_last_lane(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(LANES - 1);
  endfunction

endpackage

// File: rtl/r4_out_serializer_group_slot.sv
// One group slot: 4-lane complex register bank, whole-group write, lane-select read.
// Latency: write visible one cycle after i_we; read is combinational on i_sel.
// Backpressure: none; the owner guarantees no write while the slot is being read.
module r4_group_slot
  import r4_out_serializer_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [LANES*WL-1:0]   i_re,
  input  logic [LANES*WL-1:0]   i_im,
  input  logic [IDX_W-1:0]      i_sel,
  output logic [WL-1:0]         o_re,
  output logic [WL-1:0]         o_im
);

  logic [LANES*WL-1:0] r_re;
  logic [LANES*WL-1:0] r_im;

  // Capture the full group on write enable; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_re <= '0;
      r_im <= '0;
    end else if (i_we) begin
      r_re <= i_re;
      r_im <= i_im;
    end
  end

  assign o_re = r_re[i_sel*WL +: WL];
  assign o_im = r_im[i_sel*WL +: WL];

endmodule

// File: rtl/r4_out_serializer.sv
// Radix-4 output serializer: 4-lane groups in, one complex sample per accepted cycle out.
// Latency: lane 1 of a group is presented the cycle after the group is pushed.
// Backpressure: out_ready stalls the stream; a full buffer drops offered groups and sets sticky overflow.
module r4_out_serializer
  import r4_out_serializer_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WL-1:0] in1_r,
  input  logic [WL-1:0] in1_i,
  input  logic [WL-1:0] in2_r,
  input  logic [WL-1:0] in2_i,
  input  logic [WL-1:0] in3_r,
  input  logic [WL-1:0] in3_i,
  input  logic [WL-1:0] in4_r,
  input  logic [WL-1:0] in4_i,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [WL-1:0] out_r,
  output logic [WL-1:0] out_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_idx,
  output logic          out_last,
  output logic          overflow
);

  logic [1:0]       r_count;
  logic [IDX_W-1:0] r_idx;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             r_overflow;

  logic                w_push;
  logic                w_pop;
  logic                w_done;
  logic [LANES*WL-1:0] w_in_re;
  logic [LANES*WL-1:0] w_in_im;
  logic [WL-1:0]       w_re0, w_im0, w_re1, w_im1;

  // Lane 1 sits in the least significant word of the packed group.
  assign w_in_re = {in4_r, in3_r, in2_r, in1_r};
  assign w_in_im = {in4_i, in3_i, in2_i, in1_i};

  // Ready depends only on registered occupancy; no bypass when full.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_done    = w_pop & is_last_lane(r_idx);

  r4_group_slot #(.WL(WL)) u_slot0 (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_push & ~r_wr_ptr),
    .i_re  (w_in_re),
    .i_im  (w_in_im),
    .i_sel (r_idx),
    .o_re  (w_re0),
    .o_im  (w_im0)
  );

  r4_group_slot #(.WL(WL)) u_slot1 (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_push & r_wr_ptr),
    .i_re  (w_in_re),
    .i_im  (w_in_im),
    .i_sel (r_idx),
    .o_re  (w_re1),
    .o_im  (w_im1)
  );

  assign out_r    = r_rd_ptr ? w_re1 : w_re0;
  assign out_i    = r_rd_ptr ? w_im1 : w_im0;
  assign out_idx  = r_idx;
  assign out_last = out_valid & is_last_lane(r_idx);
  assign overflow = r_overflow;

  // Ping-pong pointers, lane index, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_idx      <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_idx    <= r_idx + IDX_W'(1);
      if (w_done) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_done})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (in_valid && !in_ready) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_r4_out_serializer.sv
module tb_r4_out_serializer;

  logic        clk;
  logic        rst;
  logic [15:0] in1_r, in1_i, in2_r, in2_i, in3_r, in3_i, in4_r, in4_i;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_r, out_i;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  r4_out_serializer #(.WL(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1_r     (in1_r),
    .in1_i     (in1_i),
    .in2_r     (in2_r),
    .in2_i     (in2_i),
    .in3_r     (in3_r),
    .in3_i     (in3_i),
    .in4_r     (in4_r),
    .in4_i     (in4_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Group g, lane l (1..4): real = g<<8 | l, imag = g<<8 | l*0x11.
  function automatic logic [15:0] lr(input int g, input int l);
    return 16'((g << 8) | l);
  endfunction

  function automatic logic [15:0] li(input int g, input int l);
    return 16'((g << 8) | (l * 17));
  endfunction

  task automatic set_grp(input int g);
    in1_r = lr(g, 1); in1_i = li(g, 1);
    in2_r = lr(g, 2); in2_i = li(g, 2);
    in3_r = lr(g, 3); in3_i = li(g, 3);
    in4_r = lr(g, 4); in4_i = li(g, 4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g);
    set_grp(g);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic exp_s(input string tag, input int g, input int l);
    chk({tag, ".vld"},  32'(out_valid), 32'd1);
    chk({tag, ".re"},   32'(out_r),     32'(lr(g, l)));
    chk({tag, ".im"},   32'(out_i),     32'(li(g, l)));
    chk({tag, ".idx"},  32'(out_idx),   32'(l - 1));
    chk({tag, ".last"}, 32'(out_last),  32'(l == 4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_grp(0);
    #3;
    chk("rst.vld",   32'(out_valid), 32'd0);
    chk("rst.re",    32'(out_r),     32'd0);
    chk("rst.im",    32'(out_i),     32'd0);
    chk("rst.idx",   32'(out_idx),   32'd0);
    chk("rst.last",  32'(out_last),  32'd0);
    chk("rst.rdy",   32'(in_ready),  32'd1);
    chk("rst.ovf",   32'(overflow),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single group, continuous out_ready.
    out_ready = 1'b1;
    push(0);
    for (int l = 1; l <= 4; l++) begin
      exp_s("t1", 0, l);
      chk("t1.rdy", 32'(in_ready), 32'd1);
      tick();
    end
    chk("t1.idle", 32'(out_valid), 32'd0);

    // Eight groups, one every four cycles: gapless stream.
    for (int g = 1; g <= 8; g++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          set_grp(g);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        tick();
        exp_s("t2", g, c + 1);
        chk("t2.rdy", 32'(in_ready), 32'd1);
        chk("t2.ovf", 32'(overflow), 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t2.idle", 32'(out_valid), 32'd0);

    // Stalled consumer: fill both slots, third group dropped.
    do_reset();
    push(10);
    chk("t3.rdy1", 32'(in_ready), 32'd1);
    exp_s("t3.h1", 10, 1);
    push(11);
    chk("t3.rdy2", 32'(in_ready), 32'd0);
    chk("t3.ovf0", 32'(overflow), 32'd0);
    exp_s("t3.h2", 10, 1);
    push(12);
    chk("t3.ovf1", 32'(overflow), 32'd1);
    chk("t3.rdy3", 32'(in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_s("t3.hold", 10, 1);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_s("t3.drain", (n < 4) ? 10 : 11, (n % 4) + 1);
      tick();
    end
    chk("t3.idle", 32'(out_valid), 32'd0);
    chk("t3.rdy4", 32'(in_ready), 32'd1);

    // Full buffer: offer coincides with final pop of first group.
    do_reset();
    push(20);
    push(21);
    exp_s("t4.a1", 20, 1);
    out_ready = 1'b1;
    tick(); exp_s("t4.a2", 20, 2);
    tick(); exp_s("t4.a3", 20, 3);
    tick(); exp_s("t4.a4", 20, 4);
    chk("t4.rdy0", 32'(in_ready), 32'd0);
    push(22);
    chk("t4.ovf", 32'(overflow), 32'd1);
    chk("t4.rdy1", 32'(in_ready), 32'd1);
    exp_s("t4.b1", 21, 1);
    for (int l = 2; l <= 4; l++) begin
      tick();
      exp_s("t4.b", 21, l);
    end
    tick();
    chk("t4.idle", 32'(out_valid), 32'd0);

    // Push and group-completing pop on the same edge with one group held.
    do_reset();
    out_ready = 1'b1;
    push(30);
    exp_s("t5.a1", 30, 1);
    tick(); exp_s("t5.a2", 30, 2);
    tick(); exp_s("t5.a3", 30, 3);
    tick(); exp_s("t5.a4", 30, 4);
    push(31);
    exp_s("t5.b1", 31, 1);
    chk("t5.rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_s("t5.hold", 31, 1);
    end
    out_ready = 1'b1;
    for (int l = 2; l <= 4; l++) begin
      tick();
      exp_s("t5.b", 31, l);
    end
    tick();
    chk("t5.idle", 32'(out_valid), 32'd0);
    chk("t5.rdyi", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-group clears everything including overflow.
    do_reset();
    push(40);
    push(41);
    push(42);
    chk("t6.ovf1", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    exp_s("t6.a3", 40, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.vld",  32'(out_valid), 32'd0);
    chk("t6.rdy",  32'(in_ready),  32'd1);
    chk("t6.ovf0", 32'(overflow),  32'd0);
    chk("t6.idx",  32'(out_idx),   32'd0);
    chk("t6.re",   32'(out_r),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(43);
    for (int l = 1; l <= 4; l++) begin
      exp_s("t6.b", 43, l);
      tick();
    end
    chk("t6.idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
